// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit that fronts the word-wide
// memory block.
package lsu_pkg;

  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} lsu_size_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

  localparam int BYTES_PER_WORD = 4;

  // Size 2'b11 has no encoding, so it is always treated as an error.
  function automatic logic is_misaligned(input logic [1:0] lane, input logic [1:0] size);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and memory-side signals of the load/store unit.
// The slave modport is the unit itself; master is the core plus memory.
interface lsu_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: MERGE=0 extracts and extends a
// load field, MERGE=1 splices store data into the old word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter bit MERGE = 1'b0
) (
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  lsu_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] ext_s;
  logic [31:0] merged_s;

  // Load path: pick the addressed field and sign- or zero-extend it.
  always_comb begin
    byte_s = word[{lane, 3'b000} +: 8];
    half_s = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SIZE_B:  ext_s = {{24{~is_unsigned & byte_s[7]}}, byte_s};
      SIZE_H:  ext_s = {{16{~is_unsigned & half_s[15]}}, half_s};
      SIZE_W:  ext_s = word;
      default: ext_s = 32'd0;
    endcase
  end

  // Store path: replace only the addressed lane, keep the rest of the old word.
  always_comb begin
    merged_s = word;
    case (size)
      SIZE_B:  merged_s[{lane, 3'b000} +: 8] = wdata[7:0];
      SIZE_H:  merged_s[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      SIZE_W:  merged_s = wdata;
      default: merged_s = word;
    endcase
  end

  assign result = MERGE ? merged_s : ext_s;

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit; sub-word stores are done as
// read-modify-write because the memory has no byte enables.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  lsu_state_t            state_r;
  lsu_state_t            state_next_s;
  logic [1:0]            lane_r;
  lsu_size_t             size_r;
  logic                  unsigned_r;
  logic                  write_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  req_ready_r;
  logic                  resp_valid_r;
  logic [DATA_WIDTH-1:0] resp_rdata_r;
  logic                  resp_err_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  mem_we_r;
  logic                  accept_s;
  logic                  bad_s;
  logic [31:0]           extracted_s;
  logic [31:0]           merged_s;

  assign accept_s = bus.req_valid && req_ready_r;
  assign bad_s    = is_misaligned(bus.req_addr[1:0], bus.req_size);

  lsu_align #(.MERGE(1'b0)) u_extract (
    .word        (bus.mem_rdata),
    .wdata       (wdata_r),
    .lane        (lane_r),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .result      (extracted_s)
  );

  lsu_align #(.MERGE(1'b1)) u_merge (
    .word        (bus.mem_rdata),
    .wdata       (wdata_r),
    .lane        (lane_r),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .result      (merged_s)
  );

  // Next-state logic; sub-word stores go through READ to fetch the old word.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_next_s = IDLE;
        end else if (bad_s) begin
          state_next_s = RESP;
        end else if (bus.req_write && (bus.req_size == SIZE_W)) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = READ;
        end
      end
      READ:    state_next_s = write_r ? WRITE : RESP;
      WRITE:   state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      lane_r       <= 2'b00;
      size_r       <= SIZE_B;
      unsigned_r   <= 1'b0;
      write_r      <= 1'b0;
      wdata_r      <= '0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= '0;
      resp_err_r   <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      mem_we_r     <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      req_ready_r  <= (state_next_s == IDLE);
      resp_valid_r <= (state_next_s == RESP);
      mem_we_r     <= (state_next_s == WRITE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            lane_r     <= bus.req_addr[1:0];
            size_r     <= lsu_size_t'(bus.req_size);
            unsigned_r <= bus.req_unsigned;
            write_r    <= bus.req_write;
            wdata_r    <= bus.req_wdata;
            mem_addr_r <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (bad_s) begin
              resp_err_r   <= 1'b1;
              resp_rdata_r <= '0;
            end else if (bus.req_write && (bus.req_size == SIZE_W)) begin
              mem_wdata_r <= bus.req_wdata;
            end
          end
        end
        READ: begin
          if (write_r) begin
            mem_wdata_r <= merged_s;
          end else begin
            resp_rdata_r <= extracted_s;
            resp_err_r   <= 1'b0;
          end
        end
        WRITE: begin
          resp_rdata_r <= '0;
          resp_err_r   <= 1'b0;
        end
        default: begin
          resp_err_r <= resp_err_r;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.mem_we     = mem_we_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 64-word memory and a
// response scoreboard.
module tb_load_store_unit;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [32:0] exp_q[$];
  string       cur_tag;
  logic [31:0] mem [64];

  lsu_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL %s_unexpected_resp: got resp_valid 1 expected 0", cur_tag);
      end
      if (exp_q.size() != 0) begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check({cur_tag, "_rdata"}, bus.resp_rdata, e[31:0]);
        check({cur_tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, e[32]});
      end
    end
  end

  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         input int exp_we, input logic [31:0] exp_mwd);
    int lat;
    int we_cnt;
    lat = -1;
    we_cnt = 0;
    @(negedge clk);
    cur_tag = tag;
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    exp_q.push_back({exp_err, exp_rd});
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1 && !exp_err) check({tag, "_mem_addr"}, {24'd0, bus.mem_addr}, {24'd0, addr[7:2], 2'b00});
      if (bus.mem_we === 1'b1) begin
        we_cnt++;
        check({tag, "_mem_wdata"}, bus.mem_wdata, exp_mwd);
      end
      if (bus.resp_valid === 1'b1 && lat < 0) lat = k;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_we_cycles"}, we_cnt, exp_we);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_cnt;
    tests = 0;
    fails = 0;
    cur_tag = "reset";
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 8'd0;
    bus.req_wdata    = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);

    //        tag          wr    size   uns   addr   wdata          exp_rdata      err  lat we mem_wdata
    run_req("ld_w_00",   1'b0, 2'b10, 1'b0, 8'h00, 32'd0,         32'h00000000, 1'b0, 2, 0, 32'd0);
    run_req("st_w_04",   1'b1, 2'b10, 1'b0, 8'h04, 32'hDEADBEEF,  32'h00000000, 1'b0, 2, 1, 32'hDEADBEEF);
    run_req("ld_w_04",   1'b0, 2'b10, 1'b0, 8'h04, 32'd0,         32'hDEADBEEF, 1'b0, 2, 0, 32'd0);
    run_req("st_b_05",   1'b1, 2'b00, 1'b0, 8'h05, 32'h00000012,  32'h00000000, 1'b0, 3, 1, 32'hDEAD12EF);
    run_req("ld_w_04b",  1'b0, 2'b10, 1'b0, 8'h04, 32'd0,         32'hDEAD12EF, 1'b0, 2, 0, 32'd0);
    run_req("ld_b_07s",  1'b0, 2'b00, 1'b0, 8'h07, 32'd0,         32'hFFFFFFDE, 1'b0, 2, 0, 32'd0);
    run_req("ld_b_07u",  1'b0, 2'b00, 1'b1, 8'h07, 32'd0,         32'h000000DE, 1'b0, 2, 0, 32'd0);
    run_req("ld_h_06s",  1'b0, 2'b01, 1'b0, 8'h06, 32'd0,         32'hFFFFDEAD, 1'b0, 2, 0, 32'd0);
    run_req("ld_b_04s",  1'b0, 2'b00, 1'b0, 8'h04, 32'd0,         32'hFFFFFFEF, 1'b0, 2, 0, 32'd0);
    run_req("ld_w_06",   1'b0, 2'b10, 1'b0, 8'h06, 32'd0,         32'h00000000, 1'b1, 1, 0, 32'd0);
    run_req("st_h_05",   1'b1, 2'b01, 1'b0, 8'h05, 32'h0000AAAA,  32'h00000000, 1'b1, 1, 0, 32'd0);
    run_req("ld_sz11",   1'b0, 2'b11, 1'b0, 8'h04, 32'd0,         32'h00000000, 1'b1, 1, 0, 32'd0);
    check("mem_04_after_err", mem[1], 32'hDEAD12EF);
    run_req("st_h_06",   1'b1, 2'b01, 1'b0, 8'h06, 32'h00001234,  32'h00000000, 1'b0, 3, 1, 32'h123412EF);
    run_req("st_w_fc",   1'b1, 2'b10, 1'b0, 8'hFC, 32'h80000001,  32'h00000000, 1'b0, 2, 1, 32'h80000001);
    run_req("ld_h_feu",  1'b0, 2'b01, 1'b1, 8'hFE, 32'd0,         32'h00008000, 1'b0, 2, 0, 32'd0);
    run_req("st_h_04",   1'b1, 2'b01, 1'b0, 8'h04, 32'h0000BEEF,  32'h00000000, 1'b0, 3, 1, 32'h1234BEEF);
    run_req("st_b_06",   1'b1, 2'b00, 1'b0, 8'h06, 32'h000000AD,  32'h00000000, 1'b0, 3, 1, 32'h12ADBEEF);
    run_req("st_b_07",   1'b1, 2'b00, 1'b0, 8'h07, 32'h000000DE,  32'h00000000, 1'b0, 3, 1, 32'hDEADBEEF);
    run_req("st_b_05b",  1'b1, 2'b00, 1'b0, 8'h05, 32'h00000012,  32'h00000000, 1'b0, 3, 1, 32'hDEAD12EF);
    run_req("ld_h_04u",  1'b0, 2'b01, 1'b1, 8'h04, 32'd0,         32'h000012EF, 1'b0, 2, 0, 32'd0);

    // Abort a sub-word store during its READ cycle.
    cur_tag = "abort";
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 8'h04;
    bus.req_wdata    = 32'h00000077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    we_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) we_cnt++;
      if (k == 0) begin
        check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort_rdata_cleared", bus.resp_rdata, 32'd0);
      end
    end
    check("abort_we_cycles", we_cnt, 0);
    check("abort_mem_04", mem[1], 32'hDEAD12EF);
    run_req("ld_w_04c",  1'b0, 2'b10, 1'b0, 8'h04, 32'd0,         32'hDEAD12EF, 1'b0, 2, 0, 32'd0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
